// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    // Execute-stage operand source select.
    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    // Multi-cycle sequencing state.
    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        DRAIN    = 2'b10
    } hz_state_t;

    // result_src encoding that marks a load in execute.
    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/forward_sel.sv
// Forwarding source select for one execute-stage operand.
module forward_sel
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] rs_e_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_m_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_w_i,
    input  logic                      reg_write_m_i,
    input  logic                      reg_write_w_i,
    output fwd_sel_t                  fwd_sel_o
);

    logic hit_m;
    logic hit_w;

    // x0 is hardwired to zero, so a write to it never produces a forwardable value.
    assign hit_m = reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs_e_i);
    assign hit_w = reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_e_i);

    // Youngest producer (M) wins over the older one (W).
    always_comb begin
        if (hit_m) begin
            fwd_sel_o = FWD_M;
        end else if (hit_w) begin
            fwd_sel_o = FWD_W;
        end else begin
            fwd_sel_o = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline controller: operand forwarding, load-use and branch hazards,
// memory wait and fence/ecall drain sequencing, plus a stall-cycle counter.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_e,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_e,
    input  logic [REG_ADDR_WIDTH-1:0] rd_e,
    input  logic [REG_ADDR_WIDTH-1:0] rd_m,
    input  logic [REG_ADDR_WIDTH-1:0] rd_w,
    input  logic                      reg_write_m,
    input  logic                      reg_write_w,
    input  logic                      load_e,
    input  logic                      pc_src_e,
    input  logic                      fence_d,
    input  logic                      valid_e,
    input  logic                      valid_m,
    input  logic                      valid_w,
    input  logic                      mem_req_m,
    input  logic                      mem_ready_m,
    output logic [1:0]                fwd_a_e,
    output logic [1:0]                fwd_b_e,
    output logic                      stall_f,
    output logic                      stall_d,
    output logic                      stall_e,
    output logic                      stall_m,
    output logic                      flush_d,
    output logic                      flush_e,
    output logic                      flush_w,
    output logic [CNT_WIDTH-1:0]      stall_cnt
);

    hz_state_t            state_q, state_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    fwd_sel_t fwd_a;
    fwd_sel_t fwd_b;

    logic mem_wait_req;
    logic memhold;
    logic lu;
    logic drn;
    logic empty;
    logic drain_done;

    // ---------------------------------------------------------------------
    // Operand forwarding
    // ---------------------------------------------------------------------
    forward_sel #(
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_fwd_a (
        .rs_e_i        (rs1_e),
        .rd_m_i        (rd_m),
        .rd_w_i        (rd_w),
        .reg_write_m_i (reg_write_m),
        .reg_write_w_i (reg_write_w),
        .fwd_sel_o     (fwd_a)
    );

    forward_sel #(
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_fwd_b (
        .rs_e_i        (rs2_e),
        .rd_m_i        (rd_m),
        .rd_w_i        (rd_w),
        .reg_write_m_i (reg_write_m),
        .reg_write_w_i (reg_write_w),
        .fwd_sel_o     (fwd_b)
    );

    assign fwd_a_e = fwd_a;
    assign fwd_b_e = fwd_b;

    // ---------------------------------------------------------------------
    // Hazard condition terms
    // ---------------------------------------------------------------------
    assign mem_wait_req = mem_req_m && !mem_ready_m;
    assign memhold      = (state_q == MEM_WAIT) || mem_wait_req;
    assign lu           = load_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
    assign drn          = (state_q == DRAIN) || fence_d;
    assign empty        = !valid_e && !valid_m && !valid_w;
    // The fence is released in the very cycle the back end is seen empty.
    assign drain_done   = (state_q == DRAIN) && empty;

    // Prioritised stall/flush enables; forced quiet while reset is asserted.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (rst_n) begin
            if (memhold && !mem_ready_m) begin
                // Freeze F..M; W gets bubbles so a retired result is not re-written.
                // A taken branch in E is held here and flushes once memory releases.
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
            end else if (pc_src_e) begin
                // Squash the wrong-path instructions in D and E; a load-use
                // stall on the wrong path is moot.
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (lu) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end else if (drn && !drain_done) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Sequencing FSM
    // ---------------------------------------------------------------------

    // Next-state selection for memory waits and fence drains.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (mem_wait_req) begin
                    state_d = MEM_WAIT;
                end else if (fence_d && !pc_src_e && !lu) begin
                    state_d = DRAIN;
                end
            end
            MEM_WAIT: begin
                // A fence still waiting in D re-enters DRAIN from RUN later.
                if (mem_ready_m) begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (mem_wait_req) begin
                    state_d = MEM_WAIT;
                end else if (empty) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Saturating count of fetch-stall cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_f && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus a randomized
// run against a behavioural model of the hazard rules.
module tb_hazard_unit;

    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic          reg_write_m, reg_write_w, load_e, pc_src_e, fence_d;
    logic          valid_e, valid_m, valid_w, mem_req_m, mem_ready_m;

    logic [1:0]    fwd_a_e, fwd_b_e;
    logic          stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;
    logic [31:0]   stall_cnt;

    logic [1:0]    s_fwd_a, s_fwd_b;
    logic          s_sf, s_sd, s_se, s_sm, s_fd, s_fe, s_fw;
    logic [3:0]    s_cnt;

    logic [6:0]    ctl;
    assign ctl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w};

    int n_checks = 0;
    int n_fail   = 0;

    // Model: 0 = running, 1 = waiting on memory, 2 = draining for a fence.
    int      m_state;
    longint  m_cnt;

    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_MEM  = 7'b1111001;
    localparam logic [6:0] C_BR   = 7'b0000110;
    localparam logic [6:0] C_LU   = 7'b1100010;

    always #5 clk = ~clk;

    hazard_unit #(.REG_ADDR_WIDTH(AW), .CNT_WIDTH(32)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .rd_m(rd_m), .rd_w(rd_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .load_e(load_e), .pc_src_e(pc_src_e), .fence_d(fence_d),
        .valid_e(valid_e), .valid_m(valid_m), .valid_w(valid_w),
        .mem_req_m(mem_req_m), .mem_ready_m(mem_ready_m),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
        .stall_cnt(stall_cnt)
    );

    hazard_unit #(.REG_ADDR_WIDTH(AW), .CNT_WIDTH(4)) u_dut_sat (
        .clk(clk), .rst_n(rst_n),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .rd_m(rd_m), .rd_w(rd_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .load_e(load_e), .pc_src_e(pc_src_e), .fence_d(fence_d),
        .valid_e(valid_e), .valid_m(valid_m), .valid_w(valid_w),
        .mem_req_m(mem_req_m), .mem_ready_m(mem_ready_m),
        .fwd_a_e(s_fwd_a), .fwd_b_e(s_fwd_b),
        .stall_f(s_sf), .stall_d(s_sd), .stall_e(s_se), .stall_m(s_sm),
        .flush_d(s_fd), .flush_e(s_fe), .flush_w(s_fw),
        .stall_cnt(s_cnt)
    );

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic int ref_fwd(input logic [AW-1:0] rs);
        if (reg_write_m && rd_m != 0 && rd_m == rs) return 2;
        if (reg_write_w && rd_w != 0 && rd_w == rs) return 1;
        return 0;
    endfunction

    function automatic bit ref_lu();
        return load_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
    endfunction

    function automatic logic [6:0] ref_ctl(input int st);
        bit all_gone;
        all_gone = !(valid_e || valid_m || valid_w);
        if (!rst_n) return C_NONE;
        // Memory not ready while a request or an outstanding wait exists.
        if (!mem_ready_m && (st == 1 || mem_req_m)) return C_MEM;
        if (pc_src_e) return C_BR;
        if (ref_lu()) return C_LU;
        if ((st == 2 || fence_d) && !(st == 2 && all_gone)) return C_LU;
        return C_NONE;
    endfunction

    function automatic int ref_next(input int st);
        bit blocked;
        blocked = mem_req_m && !mem_ready_m;
        case (st)
            1: return mem_ready_m ? 0 : 1;
            2: return blocked ? 1 : (!(valid_e || valid_m || valid_w) ? 0 : 2);
            default: return blocked ? 1 : ((fence_d && !pc_src_e && !ref_lu()) ? 2 : 0);
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic clear_inputs();
        rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
        reg_write_m = 0; reg_write_w = 0; load_e = 0; pc_src_e = 0; fence_d = 0;
        valid_e = 1; valid_m = 1; valid_w = 1; mem_req_m = 0; mem_ready_m = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        rst_n = 1'b1;
        m_state = 0;
        m_cnt   = 0;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        mem_req_m = 1; mem_ready_m = 0; fence_d = 1; pc_src_e = 1;
        load_e = 1; rd_e = 3; rs1_d = 3; rs1_e = 4; rd_m = 4;
        #2;
        n_checks++;
        if (ctl !== C_NONE) begin
            n_fail++; $display("FAIL reset_ctl: got %b want %b", ctl, C_NONE);
        end
        n_checks++;
        if (stall_cnt !== 32'd0) begin
            n_fail++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt);
        end
        n_checks++;
        if (fwd_a_e !== 2'b00) begin
            n_fail++; $display("FAIL reset_fwd: got %b want 00", fwd_a_e);
        end
        do_reset();
    endtask

    task automatic test_forwarding();
        clear_inputs();
        rs1_e = 5; rd_m = 5; reg_write_m = 1; rd_w = 5; reg_write_w = 1;
        #1;
        n_checks++;
        if (fwd_a_e !== 2'b10) begin
            n_fail++; $display("FAIL fwd_m_wins: got %b want 10", fwd_a_e);
        end
        rd_m = 0; #1;
        n_checks++;
        if (fwd_a_e !== 2'b01) begin
            n_fail++; $display("FAIL fwd_x0_m: got %b want 01", fwd_a_e);
        end
        rs1_e = 0; #1;
        n_checks++;
        if (fwd_a_e !== 2'b00) begin
            n_fail++; $display("FAIL fwd_rs_x0: got %b want 00", fwd_a_e);
        end
        rs2_e = 7; rd_m = 7; rd_w = 7; #1;
        n_checks++;
        if (fwd_b_e !== 2'b10) begin
            n_fail++; $display("FAIL fwd_b_m: got %b want 10", fwd_b_e);
        end
        reg_write_m = 0; #1;
        n_checks++;
        if (fwd_b_e !== 2'b01) begin
            n_fail++; $display("FAIL fwd_b_w: got %b want 01", fwd_b_e);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        load_e = 1; rd_e = 3; rs2_d = 3; rs1_d = 9;
        #1;
        n_checks++;
        if (ctl !== C_LU) begin
            n_fail++; $display("FAIL lu_stall: got %b want %b", ctl, C_LU);
        end
        tick();
        load_e = 0; #1;
        n_checks++;
        if (stall_cnt !== 32'd1) begin
            n_fail++; $display("FAIL lu_cnt: got %0d want 1", stall_cnt);
        end
        load_e = 1; rd_e = 0; rs2_d = 0; #1;
        n_checks++;
        if (ctl !== C_NONE) begin
            n_fail++; $display("FAIL lu_x0: got %b want %b", ctl, C_NONE);
        end
        clear_inputs();
    endtask

    task automatic test_branch_vs_load_use();
        // Counter is 1 from the load-use test.
        load_e = 1; rd_e = 3; rs2_d = 3; pc_src_e = 1;
        #1;
        n_checks++;
        if (ctl !== C_BR) begin
            n_fail++; $display("FAIL br_over_lu: got %b want %b", ctl, C_BR);
        end
        tick();
        n_checks++;
        if (stall_cnt !== 32'd1) begin
            n_fail++; $display("FAIL br_cnt: got %0d want 1", stall_cnt);
        end
        clear_inputs();
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_req_m = 1; mem_ready_m = 0; pc_src_e = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (ctl !== C_MEM) begin
                n_fail++; $display("FAIL mem_hold_%0d: got %b want %b", i, ctl, C_MEM);
            end
            tick();
            mem_req_m = (i == 0) ? 1'b0 : mem_req_m;  // wait must persist from state alone
        end
        mem_ready_m = 1; #1;
        n_checks++;
        if (ctl !== C_BR) begin
            n_fail++; $display("FAIL mem_release: got %b want %b", ctl, C_BR);
        end
        n_checks++;
        if (stall_cnt !== 32'd3) begin
            n_fail++; $display("FAIL mem_cnt: got %0d want 3", stall_cnt);
        end
        tick();
        clear_inputs();
        mem_req_m = 1; mem_ready_m = 1; #1;
        n_checks++;
        if (ctl !== C_NONE) begin
            n_fail++; $display("FAIL mem_same_cycle: got %b want %b", ctl, C_NONE);
        end
        clear_inputs();
    endtask

    task automatic test_drain();
        do_reset();
        fence_d = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (ctl !== C_LU) begin
                n_fail++; $display("FAIL drain_hold_%0d: got %b want %b", i, ctl, C_LU);
            end
            tick();
            if (i == 0) valid_w = 0;
            if (i == 1) valid_m = 0;
            if (i == 2) valid_e = 0;
        end
        #1;
        n_checks++;
        if (ctl !== C_NONE) begin
            n_fail++; $display("FAIL drain_empty: got %b want %b", ctl, C_NONE);
        end
        tick();
        fence_d = 0; valid_e = 1; valid_m = 1; valid_w = 1; #1;
        n_checks++;
        if (ctl !== C_NONE) begin
            n_fail++; $display("FAIL drain_to_run: got %b want %b", ctl, C_NONE);
        end
        n_checks++;
        if (stall_cnt !== 32'd3) begin
            n_fail++; $display("FAIL drain_cnt: got %0d want 3", stall_cnt);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        fence_d = 1;
        tick();
        tick();
        rst_n = 0; #1;
        n_checks++;
        if (ctl !== C_NONE || stall_cnt !== 32'd0) begin
            n_fail++; $display("FAIL rst_in_drain: got %b/%0d want %b/0", ctl, stall_cnt, C_NONE);
        end
        tick();
        rst_n = 1; fence_d = 0; #1;
        n_checks++;
        if (ctl !== C_NONE) begin
            n_fail++; $display("FAIL rst_no_residue: got %b want %b", ctl, C_NONE);
        end
        clear_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        mem_req_m = 1; mem_ready_m = 0;
        repeat (20) tick();
        n_checks++;
        if (s_cnt !== 4'd15) begin
            n_fail++; $display("FAIL sat_hold: got %0d want 15", s_cnt);
        end
        n_checks++;
        if (stall_cnt !== 32'd20) begin
            n_fail++; $display("FAIL sat_wide: got %0d want 20", stall_cnt);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_random();
        logic [6:0] e;
        int         ns;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst_n       = ($urandom_range(0, 99) != 0);
            rs1_d       = AW'($urandom_range(0, 3));
            rs2_d       = AW'($urandom_range(0, 3));
            rs1_e       = AW'($urandom_range(0, 3));
            rs2_e       = AW'($urandom_range(0, 3));
            rd_e        = AW'($urandom_range(0, 3));
            rd_m        = AW'($urandom_range(0, 3));
            rd_w        = AW'($urandom_range(0, 3));
            reg_write_m = $urandom_range(0, 1) == 1;
            reg_write_w = $urandom_range(0, 1) == 1;
            load_e      = $urandom_range(0, 3) == 0;
            pc_src_e    = $urandom_range(0, 5) == 0;
            fence_d     = $urandom_range(0, 4) == 0;
            valid_e     = $urandom_range(0, 1) == 1;
            valid_m     = $urandom_range(0, 1) == 1;
            valid_w     = $urandom_range(0, 1) == 1;
            mem_req_m   = $urandom_range(0, 2) == 0;
            mem_ready_m = $urandom_range(0, 2) != 0;
            if (!rst_n) begin
                m_state = 0;
                m_cnt   = 0;
            end
            #1;
            e = ref_ctl(m_state);
            n_checks++;
            if (ctl !== e) begin
                n_fail++; $display("FAIL rnd_ctl c%0d st%0d: got %b want %b", c, m_state, ctl, e);
            end
            n_checks++;
            if (fwd_a_e !== 2'(ref_fwd(rs1_e)) || fwd_b_e !== 2'(ref_fwd(rs2_e))) begin
                n_fail++;
                $display("FAIL rnd_fwd c%0d: got %b/%b want %0d/%0d", c, fwd_a_e, fwd_b_e,
                         ref_fwd(rs1_e), ref_fwd(rs2_e));
            end
            n_checks++;
            if (stall_cnt !== 32'(m_cnt) || s_cnt !== 4'((m_cnt > 15) ? 15 : m_cnt)) begin
                n_fail++;
                $display("FAIL rnd_cnt c%0d: got %0d/%0d want %0d", c, stall_cnt, s_cnt, m_cnt);
            end
            ns = ref_next(m_state);
            @(posedge clk);
            if (rst_n) begin
                m_state = ns;
                if (e[6]) m_cnt++;
            end
            #1;
        end
        clear_inputs();
        rst_n = 1;
    endtask

    // Safety net so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        clear_inputs();
        rst_n = 0;
        m_state = 0;
        m_cnt = 0;
        #3;
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch_vs_load_use();
        test_mem_wait();
        test_drain();
        test_reset_mid_drain();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline controller for the five-stage RV32I core. It sits beside the fetch/decode/execute/memory/writeback registers and does four things: selects execute-stage operand forwarding, detects load-use hazards, flushes on taken branches, and sequences multi-cycle events. Those events are data-memory wait states and fence/ecall drains. It drives every stall/flush enable of the pipeline registers and keeps a saturating stall-cycle counter.

## Interface
- `REG_ADDR_WIDTH`, default 5: register address width.
- `CNT_WIDTH`, default 32: stall counter width.

Ports:
- `clk` in 1: core clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `rs1_d`, `rs2_d` in `REG_ADDR_WIDTH`: source registers of the instruction in decode.
- `rs1_e`, `rs2_e`, `rd_e` in `REG_ADDR_WIDTH`: execute-stage sources and destination.
- `rd_m`, `rd_w` in `REG_ADDR_WIDTH`: memory- and writeback-stage destinations.
- `reg_write_m`, `reg_write_w` in 1: register-write enables of M and W.
- `load_e` in 1: execute instruction is a load (`result_src_e == 2'b01`).
- `pc_src_e` in 1: taken branch or jump resolved in execute.
- `fence_d` in 1: decode holds fence/ecall.
- `valid_e`, `valid_m`, `valid_w` in 1: stage holds a real (non-bubble) instruction.
- `mem_req_m` in 1: data-memory access in M.
- `mem_ready_m` in 1: memory completes the access this cycle.
- `fwd_a_e`, `fwd_b_e` out 2: operand source. `00` = regfile, `10` = M ALU result, `01` = W result.
- `stall_f`, `stall_d`, `stall_e`, `stall_m` out 1: hold the stage register.
- `flush_d`, `flush_e`, `flush_w` out 1: load a bubble into the stage register.
- `stall_cnt` out `CNT_WIDTH`: cycles with `stall_f` high.

## Operation
**Forwarding**, per operand, combinational:
- Select `10` if `reg_write_m` && `rd_m != 0` && `rd_m == rs_e`.
- Otherwise select `01` if `reg_write_w` && `rd_w != 0` && `rd_w == rs_e`.
- Otherwise select `00`.
- M wins over W.

**FSM states:** `RUN`, `MEM_WAIT`, `DRAIN`.

**Condition terms:**
- `memhold` = (state == `MEM_WAIT`) || (`mem_req_m` && !`mem_ready_m`).
- `lu` = `load_e` && `rd_e != 0` && (`rd_e == rs1_d` || `rd_e == rs2_d`).
- `drn` = (state == `DRAIN`) || `fence_d`.
- `empty` = !`valid_e` && !`valid_m` && !`valid_w`.

**Output priority**, highest first:
1. `memhold` && !`mem_ready_m`: assert `stall_f`, `stall_d`, `stall_e`, `stall_m`, `flush_w`. All other flushes stay 0; a branch in E is held, not lost.
2. `pc_src_e`: assert `flush_d`, `flush_e`. No stalls.
3. `lu`: assert `stall_f`, `stall_d`, `flush_e`.
4. `drn` && !(state == `DRAIN` && `empty`): assert `stall_f`, `stall_d`, `flush_e`.
5. Otherwise all stall/flush outputs are 0.

**Transitions:**
- `RUN` → `MEM_WAIT` when `mem_req_m` && !`mem_ready_m`.
- `RUN` → `DRAIN` when `fence_d` && !`pc_src_e` && !`lu` && no memory hold.
- `MEM_WAIT` → `RUN` when `mem_ready_m`. A fence still in D re-enters `DRAIN` later.
- `DRAIN` → `MEM_WAIT` when `mem_req_m` && !`mem_ready_m`.
- `DRAIN` → `RUN` when `empty`. In that cycle the stalls drop and the fence advances.

**Stall counter:**
- `stall_cnt` increments by 1 in each cycle `stall_f` is 1.
- Saturates at all-ones and never wraps.

## Timing
- Forwarding selects and all stall/flush outputs are combinational from the inputs and the registered state. Zero latency, so they act on the same edge.
- State and `stall_cnt` are registered on `posedge clk`.
- `rst_n` low, asynchronously:
  - state = `RUN`, `stall_cnt` = 0.
  - All stall/flush outputs are forced to 0 regardless of inputs.
  - `fwd_a_e`/`fwd_b_e` stay combinational and read `00` when `reg_write_*` are 0.
- Reset mid-`MEM_WAIT` or mid-`DRAIN` returns to `RUN` immediately, with no residual stall.
- `mem_ready_m` arriving in the same cycle as the request: no state change and no stall.
- Simultaneous `lu` and `pc_src_e`: the branch wins, giving a flush only with no stall.
- x0 is never forwarded and never causes a load-use stall.

## Structure
- Package `hazard_pkg`:
  - `fwd_sel_t` enum: `FWD_RF`=`2'b00`, `FWD_W`=`2'b01`, `FWD_M`=`2'b10`.
  - `hz_state_t` enum: `RUN`, `MEM_WAIT`, `DRAIN`.
  - `RESULT_SRC_LOAD` = `2'b01`.
- Sub-module `forward_sel`: combinational selection for one operand, instantiated twice (operand A and operand B).
- FSM, priority logic and counter live in `hazard_unit`.

## Test plan
- **Forwarding:** `rs1_e`=5, `rd_m`=5, `reg_write_m`=1, `rd_w`=5, `reg_write_w`=1 → `fwd_a_e`=`10`. Repeat with `rd_m`=0 → `01`. With `rs1_e`=0 → `00`.
- **Load-use:** `load_e`=1, `rd_e`=3, `rs2_d`=3 → one cycle of `stall_f`=`stall_d`=`flush_e`=1, `stall_cnt` 0→1. Same with `rd_e`=0 → no stall.
- **Branch vs load-use:** `pc_src_e`=1 together with the load-use case → `flush_d`=`flush_e`=1, `stall_f`=0, `stall_cnt` unchanged.
- **Memory wait:** `mem_req_m`=1, `mem_ready_m` low for 3 cycles → `stall_f`/`stall_d`/`stall_e`/`stall_m`/`flush_w` high 3 cycles. `mem_ready_m` high in cycle 4 releases the stalls; `stall_cnt`=3. A concurrent `pc_src_e` gives `flush_d` only after release.
- **Drain:** `fence_d`=1 with `valid_e`/`valid_m`/`valid_w` clearing over 3 cycles → stalls held until `empty`, then state `RUN` and stalls released in the `empty` cycle.
- **Reset and saturation:**
  - `rst_n` low during `DRAIN` → outputs 0 immediately, `stall_cnt`=0.
  - Counter preloaded via a `CNT_WIDTH`=4 instance and stalled 20 cycles → holds at 15.
